adder_pipe: RTL

Parametrised, pipelined successor to the single-cycle registered adder. It accepts operand pairs through a valid/ready handshake and supports add, subtract, accumulate and accumulator-clear modes. Results come out after a configurable latency with full backpressure. It sits between an operand source and a result consumer in the arithmetic datapath, at one beat per cycle when unstalled.

---
 rtl/adder_pipe.sv | 93 +++++++++
 1 files changed

// File: rtl/adder_pipe.sv
// Pipelined add/sub/accumulate unit: result appears LATENCY-1 edges after the accepting edge.
// Whole-pipe stall: shifts only when the output slot is empty or being consumed; in_ready = advance.
module adder_pipe #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [1:0]       mode,
  output logic [WIDTH:0]   out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             acc_ovf
);

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_ACC = 2'b10;
  localparam logic [1:0] MODE_CLR = 2'b11;

  logic             advance;
  logic             accept;
  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   acc_nxt;
  logic             ovf_nxt;
  logic [WIDTH+1:0] acc_sum;
  logic [WIDTH:0]   res;

  logic [WIDTH:0]     stg_dat [LATENCY];
  logic [LATENCY-1:0] stg_vld;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign accept   = in_valid && advance;

  // One extra bit above the accumulator width captures the wrap for the sticky flag.
  assign acc_sum = {1'b0, acc} + {2'b00, in1};

  always_comb begin
    res     = '0;
    acc_nxt = acc;
    ovf_nxt = acc_ovf;
    case (mode)
      MODE_ADD: res = {1'b0, in1} + {1'b0, in2};
      MODE_SUB: res = {1'b0, in1} - {1'b0, in2};
      MODE_ACC: begin
        res     = acc_sum[WIDTH:0];
        acc_nxt = acc_sum[WIDTH:0];
        if (acc_sum[WIDTH+1]) ovf_nxt = 1'b1;
      end
      MODE_CLR: begin
        res     = '0;
        acc_nxt = '0;
        ovf_nxt = 1'b0;
      end
      default: res = '0;
    endcase
  end

  // Accumulator moves only on the accepting edge, so chained ACC beats see the prior result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc     <= '0;
      acc_ovf <= 1'b0;
    end else if (accept) begin
      acc     <= acc_nxt;
      acc_ovf <= ovf_nxt;
    end
  end

  // Data registers load only behind a valid beat, so an emptied output keeps its last value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stg_vld <= '0;
      for (int i = 0; i < LATENCY; i++) stg_dat[i] <= '0;
    end else if (advance) begin
      stg_vld[0] <= in_valid;
      if (in_valid) stg_dat[0] <= res;
      for (int i = 1; i < LATENCY; i++) begin
        stg_vld[i] <= stg_vld[i-1];
        if (stg_vld[i-1]) stg_dat[i] <= stg_dat[i-1];
      end
    end
  end

  assign out       = stg_dat[LATENCY-1];
  assign out_valid = stg_vld[LATENCY-1];

endmodule
